fixed_to_uint_pipe: RTL
=======================

FIXED_TO_UINT_PIPE -- requirements
Module: fixed_to_uint_pipe

Interface
REQ-001 Parameter INT_W, default 8, integer magnitude bits of input (>=1).
REQ-002 Parameter FRAC_W, default 7, fraction bits of input (>=1); input lane width IN_W = 1+INT_W+FRAC_W.
REQ-003 Parameter OUT_W, default 16, unsigned output width per lane (>=1).
REQ-004 Parameter LANES, default 2, conversions per beat; lane k occupies bits [k*W +: W].
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  reset, asynchronous, active-low; one clock only.
REQ-007 in_valid  input  1  input beat present.
REQ-008 in_ready  output  1  block accepts beat this cycle.
REQ-009 in_data  input  LANES*IN_W  two's-complement fixed-point lanes, sign at MSB.
REQ-010 in_mode  input  2  rounding mode, travels with beat: 00 half-up, 01 truncate, 10 ceil, 11 half-even.
REQ-011 out_valid  output  1  output beat present.
REQ-012 out_ready  input  1  downstream accepts beat.
REQ-013 out_data  output  LANES*OUT_W  unsigned results.
REQ-014 out_sat_lo  output  LANES  lane input negative, clamped to 0.
REQ-015 out_sat_hi  output  LANES  lane result exceeded 2^OUT_W-1, clamped.
REQ-016 sat_count_clr  input  1  synchronous clear of sat_count.
REQ-017 sat_count  output  16  saturating count of clamped lanes.

Function
REQ-018 Two register stages S1, S2; S2 drives all out_* ports; latency in_valid&in_ready -> out_valid = 2 cycles with out_ready held 1.
REQ-019 Transfer occurs on valid&ready; S2 loads when !S2.v | out_ready; S1 loads when !S1.v | S2 loads; in_ready = S1 loads (combinational from out_ready permitted).
REQ-020 Throughput one beat/cycle when out_ready=1; no beat dropped, duplicated or reordered under any out_ready pattern.
REQ-021 While out_valid=1 and out_ready=0, out_data, out_sat_lo, out_sat_hi SHALL hold stable.
REQ-022 S1 registers per lane: sign, integer I (INT_W bits), round-increment bit r, mode; S2 computes I+r at INT_W+1 bits, then saturation.
REQ-023 r with F = fraction, H = 2^(FRAC_W-1): truncate r=0; half-up r=(F>=H); ceil r=(F!=0); half-even r=(F>H)|((F==H)&I[0]).
REQ-024 Sign=1: out lane = 0, sat_lo=1, sat_hi=0, any mode.
REQ-025 Sign=0 and I+r > 2^OUT_W-1: out lane = 2^OUT_W-1, sat_hi=1; else out lane = I+r zero-extended, both flags 0.
REQ-026 Lanes independent; one lane clamping does not affect others.
REQ-027 On each out handshake sat_count += popcount(sat_lo|sat_hi), saturating at 0xFFFF.
REQ-028 sat_count_clr with no handshake: count=0 next cycle; clr with handshake same cycle: count = that beat's increment.

Reset
REQ-029 reset_n low: S1.v, S2.v, out_valid=0, out_data=0, out_sat_lo=0, out_sat_hi=0, sat_count=0, immediately (asynchronous).
REQ-030 in_ready=1 while in reset and first cycle after release; reset mid-transfer discards all in-flight beats.
REQ-031 First beat after reset_n rise accepted on the first rising edge with in_valid=1.

Verification (defaults INT_W=8, FRAC_W=7, OUT_W=16, LANES=2 unless stated)
REQ-032 Lane 0x0140 (2.5), modes 00/01/10/11 -> 3/2/3/2; lane 0x01C0 (3.5) mode 11 -> 4; all flags 0; out_valid 2 cycles after accept.
REQ-033 Lane 0x0101 (2+1/128): mode 10 -> 3, mode 00 -> 2; lane 0x8000 -> 0, sat_lo=1, sat_count +1.
REQ-034 OUT_W=8: lane 0x7FC0 (255.5) mode 00 -> 0xFF, sat_hi=1; mode 01 -> 0xFF, sat_hi=0; OUT_W=16 mode 00 -> 256, sat_hi=0.
REQ-035 out_ready=0, in_valid=1 with 3 beats: exactly 2 accepted, in_ready=0 after, out_data stable; out_ready=1 -> beats emerge in order, third accepted same cycle.
REQ-036 sat_count at 0xFFFE plus beat with both lanes negative -> 0xFFFF; clr coincident with that beat -> 2.
REQ-037 reset_n low while S1, S2 full -> out_valid=0, sat_count=0 same cycle; no stale beat after release.

Source files
------------

// File: rtl/fixed_to_uint_pipe_if.sv
// Stream bus for fixed_to_uint_pipe. The input beat carries signed fixed-point
// lanes plus a rounding mode; the output beat carries clamped unsigned lanes.
interface fixed_to_uint_pipe_if #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 7,
  parameter int OUT_W  = 16,
  parameter int LANES  = 2
);
  localparam int IN_W = 1 + INT_W + FRAC_W;

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_data;
  logic [1:0]             in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [LANES-1:0]       out_sat_lo;
  logic [LANES-1:0]       out_sat_hi;
  logic                   sat_count_clr;
  logic [15:0]            sat_count;

  modport slave (
    input  in_valid, in_data, in_mode, out_ready, sat_count_clr,
    output in_ready, out_valid, out_data, out_sat_lo, out_sat_hi, sat_count
  );

  modport master (
    output in_valid, in_data, in_mode, out_ready, sat_count_clr,
    input  in_ready, out_valid, out_data, out_sat_lo, out_sat_hi, sat_count
  );
endinterface

// File: rtl/fixed_to_uint_pipe.sv
// Two-stage converter from signed fixed-point lanes to clamped unsigned integers.
// S1 decides the rounding increment per lane; S2 adds it and saturates.
module fixed_to_uint_pipe #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 7,
  parameter int OUT_W  = 16,
  parameter int LANES  = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  fixed_to_uint_pipe_if.slave  bus
);
  localparam int IN_W = 1 + INT_W + FRAC_W;
  // Compare width wide enough for both I+r and the output maximum.
  localparam int CW = ((INT_W + 1 > OUT_W) ? INT_W + 1 : OUT_W) + 1;
  localparam logic [31:0]       HALF32  = 32'd1 << (FRAC_W - 1);
  localparam logic [FRAC_W-1:0] HALF    = HALF32[FRAC_W-1:0];
  localparam logic [CW-1:0]     MAX_EXT = {{(CW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {
    RND_HALF_UP   = 2'b00,
    RND_TRUNC     = 2'b01,
    RND_CEIL      = 2'b10,
    RND_HALF_EVEN = 2'b11
  } rnd_mode_e;

  typedef struct packed {
    logic             sign;
    logic [INT_W-1:0] ival;
    logic             inc;
  } s1_lane_t;

  rnd_mode_e              mode;
  logic [FRAC_W-1:0]      frac;
  s1_lane_t [LANES-1:0]   s1_lane_d, s1_lane_q;
  logic                   s1_v_q, s2_v_q;
  logic                   s1_load, s2_load, out_fire;

  logic [INT_W:0]         sum;
  logic [CW-1:0]          sum_ext;
  logic [LANES*OUT_W-1:0] s2_data_d, s2_data_q;
  logic [LANES-1:0]       s2_lo_d, s2_lo_q, s2_hi_d, s2_hi_q;

  logic [15:0]            cnt_d, cnt_q, cnt_inc;
  logic [16:0]            cnt_sum;

  assign s2_load      = !s2_v_q || bus.out_ready;
  assign s1_load      = !s1_v_q || s2_load;
  assign out_fire     = s2_v_q && bus.out_ready;
  assign bus.in_ready = s1_load;

  // S1: split each lane and decide the rounding increment from the fraction.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // fall through and infer a latch.
    s1_lane_d = '0;
    frac      = '0;
    mode      = rnd_mode_e'(bus.in_mode);
    for (int k = 0; k < LANES; k++) begin
      s1_lane_d[k].sign = bus.in_data[k*IN_W + IN_W - 1];
      s1_lane_d[k].ival = bus.in_data[k*IN_W + FRAC_W +: INT_W];
      frac              = bus.in_data[k*IN_W +: FRAC_W];
      case (mode)
        RND_HALF_UP:   s1_lane_d[k].inc = (frac >= HALF);
        RND_TRUNC:     s1_lane_d[k].inc = 1'b0;
        RND_CEIL:      s1_lane_d[k].inc = (frac != '0);
        RND_HALF_EVEN: s1_lane_d[k].inc = (frac > HALF) ||
                                          ((frac == HALF) && s1_lane_d[k].ival[0]);
        default:       s1_lane_d[k].inc = 1'b0;
      endcase
    end
  end

  // S2: add the increment one bit wider than I, then clamp to the output range.
  always_comb begin
    s2_data_d = '0;
    s2_lo_d   = '0;
    s2_hi_d   = '0;
    sum       = '0;
    sum_ext   = '0;
    for (int k = 0; k < LANES; k++) begin
      sum     = {1'b0, s1_lane_q[k].ival} + (INT_W+1)'(s1_lane_q[k].inc);
      sum_ext = CW'(sum);
      if (s1_lane_q[k].sign) begin
        s2_lo_d[k] = 1'b1;
      end else if (sum_ext > MAX_EXT) begin
        s2_data_d[k*OUT_W +: OUT_W] = '1;
        s2_hi_d[k]                  = 1'b1;
      end else begin
        s2_data_d[k*OUT_W +: OUT_W] = sum_ext[OUT_W-1:0];
      end
    end
  end

  // A clear coinciding with an output handshake keeps that beat's increment.
  always_comb begin
    cnt_inc = '0;
    for (int k = 0; k < LANES; k++) begin
      cnt_inc = cnt_inc + 16'(s2_lo_q[k] | s2_hi_q[k]);
    end
    cnt_sum = {1'b0, cnt_q} + {1'b0, cnt_inc};
    cnt_d   = cnt_q;
    if (bus.sat_count_clr) begin
      cnt_d = out_fire ? cnt_inc : '0;
    end else if (out_fire) begin
      cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_lo_q   <= '0;
      s2_hi_q   <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (s1_load) s1_v_q <= bus.in_valid;
      if (s2_load) s2_v_q <= s1_v_q;
      if (s2_load && s1_v_q) begin
        s2_data_q <= s2_data_d;
        s2_lo_q   <= s2_lo_d;
        s2_hi_q   <= s2_hi_d;
      end
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the S1 payload has no reset; it is only ever observed behind s1_v_q.
  always_ff @(posedge clk) begin
    if (s1_load && bus.in_valid) s1_lane_q <= s1_lane_d;
  end

  assign bus.out_valid  = s2_v_q;
  assign bus.out_data   = s2_data_q;
  assign bus.out_sat_lo = s2_lo_q;
  assign bus.out_sat_hi = s2_hi_q;
  assign bus.sat_count  = cnt_q;
endmodule
